ram_bist: RTL

Built-in self-test controller for the dual-port RAM (32 x 8 by default). It acts as the initiator on both RAM ports: it writes a deterministic pattern through the write port, reads it back through the read port, and compares each word. It reports pass/fail, an error count and the first failing location. It sits beside the RAM in a single-clock domain; the RAM's `clk_write` and `clk_read` are both tied to `clk`.

---
 rtl/ram_bist.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ram_bist.sv
// BIST controller for a single-clock dual-port RAM: writes SEED ^ addr, reads it back, counts
// mismatches. Defining RAM_BIST_INV_PASS_EN adds a second write/read pass with the inverted pattern.
module ram_bist #(
   parameter int unsigned       ADDR_W   = 5,
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       READ_LAT = 1,
   parameter logic [DATA_W-1:0] SEED     = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass_ok,
   output logic [ADDR_W+1:0] err_count,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic [DATA_W-1:0] first_fail_data,
   output logic [ADDR_W-1:0] address_write,
   output logic [DATA_W-1:0] data_write,
   output logic              write_enable,
   output logic [ADDR_W-1:0] address_read,
   input  logic [DATA_W-1:0] data_read
);

   localparam int unsigned      DEPTH   = 2 ** ADDR_W;
   localparam int unsigned      CNT_W   = $clog2(DEPTH + READ_LAT + 2);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(DEPTH + READ_LAT);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR0  = 3'd1;
   localparam logic [2:0] S_RD0  = 3'd2;
`ifdef RAM_BIST_INV_PASS_EN
   localparam logic [2:0] S_WR1  = 3'd3;
   localparam logic [2:0] S_RD1  = 3'd4;
`endif
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]                     state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [ADDR_W+1:0]              err_q, err_d;
   logic [ADDR_W-1:0]              ffa_q, ffa_d;
   logic [DATA_W-1:0]              ffd_q, ffd_d;
   logic                           we_q, we_d;
   logic [ADDR_W-1:0]              aw_q, aw_d, ar_q, ar_d, aw_nxt, ar_nxt;
   logic [DATA_W-1:0]              dw_q, dw_d;
   logic [READ_LAT:0]              pv_q, pv_d;
   logic [READ_LAT:0][ADDR_W-1:0]  pa_q, pa_d;
   logic [READ_LAT:0][DATA_W-1:0]  pe_q, pe_d;
   logic                           inv_pass, in_write, in_read;

`ifdef RAM_BIST_INV_PASS_EN
   assign inv_pass = (state_q == S_WR1) || (state_q == S_RD1);
   assign in_write = (state_q == S_WR0) || (state_q == S_WR1);
   assign in_read  = (state_q == S_RD0) || (state_q == S_RD1);
`else
   assign inv_pass = 1'b0;
   assign in_write = (state_q == S_WR0);
   assign in_read  = (state_q == S_RD0);
`endif

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
      logic [DATA_W-1:0] p;
      p = SEED ^ DATA_W'(a);
      return inv ? ~p : p;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      ffa_d   = ffa_q;
      ffd_d   = ffd_q;
      we_d    = 1'b0;
      aw_d    = aw_q;
      dw_d    = dw_q;
      ar_d    = ar_q;
      aw_nxt  = aw_q + 1'b1;
      ar_nxt  = ar_q + 1'b1;

      // Expected data rides alongside the read; stage 0 holds the address issued at this edge.
      pv_d[0] = 1'b0;
      pa_d[0] = '0;
      pe_d[0] = '0;
      for (int i = 1; i <= int'(READ_LAT); i++) begin
         pv_d[i] = pv_q[i-1];
         pa_d[i] = pa_q[i-1];
         pe_d[i] = pe_q[i-1];
      end

      if (pv_q[READ_LAT] && (data_read != pe_q[READ_LAT])) begin
         if (err_q != '1) err_d = err_q + 1'b1;
         if (err_q == '0) begin
            ffa_d = pa_q[READ_LAT];
            ffd_d = data_read;
         end
      end

      if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
         state_d = S_IDLE;
         if (start) begin
            state_d = S_WR0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = '0;
            ffa_d   = '0;
            ffd_d   = '0;
            we_d    = 1'b1;
            aw_d    = '0;
            dw_d    = pattern('0, 1'b0);
         end
      end else if (in_write) begin
         if (cnt_q == WR_LAST) begin
            // Each read state directly follows its write state in the encoding.
            state_d = state_q + 3'd1;
            cnt_d   = '0;
            ar_d    = '0;
            pv_d[0] = 1'b1;
            pa_d[0] = '0;
            pe_d[0] = pattern('0, inv_pass);
         end else begin
            cnt_d = cnt_q + 1'b1;
            we_d  = 1'b1;
            aw_d  = aw_nxt;
            dw_d  = pattern(aw_nxt, inv_pass);
         end
      end else if (in_read) begin
         if (cnt_q == RD_LAST) begin
`ifdef RAM_BIST_INV_PASS_EN
            if (!inv_pass) begin
               state_d = S_WR1;
               cnt_d   = '0;
               we_d    = 1'b1;
               aw_d    = '0;
               dw_d    = pattern('0, 1'b1);
            end else begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end
`else
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
`endif
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q < WR_LAST) begin
               ar_d    = ar_nxt;
               pv_d[0] = 1'b1;
               pa_d[0] = ar_nxt;
               pe_d[0] = pattern(ar_nxt, inv_pass);
            end
         end
      end else begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ffa_q   <= '0;
         ffd_q   <= '0;
         we_q    <= 1'b0;
         aw_q    <= '0;
         dw_q    <= '0;
         ar_q    <= '0;
         pv_q    <= '0;
         pa_q    <= '0;
         pe_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ffa_q   <= ffa_d;
         ffd_q   <= ffd_d;
         we_q    <= we_d;
         aw_q    <= aw_d;
         dw_q    <= dw_d;
         ar_q    <= ar_d;
         pv_q    <= pv_d;
         pa_q    <= pa_d;
         pe_q    <= pe_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass_ok         = pass_q;
   assign err_count       = err_q;
   assign first_fail_addr = ffa_q;
   assign first_fail_data = ffd_q;
   assign write_enable    = we_q;
   assign address_write   = aw_q;
   assign data_write      = dw_q;
   assign address_read    = ar_q;

endmodule
